// File: rtl/fib_index.sv
// Inverse Fibonacci unit: finds the largest n with F(n) <= v (F(1)=0, F(2)=1),
// one add per iteration, with the level-sampled go / sticky done handshake.
module fib_index #(
  parameter int VALUE_WIDTH = 32,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic [VALUE_WIDTH-1:0] v,
  output logic [INDEX_WIDTH-1:0] index,
  output logic [VALUE_WIDTH-1:0] fib,
  output logic                   exact,
  output logic                   overflow,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    STEP   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] INDEX_MAX = '1;

  state_t                 state;
  logic [VALUE_WIDTH-1:0] v_r;
  logic [VALUE_WIDTH-1:0] x_r;
  logic [VALUE_WIDTH:0]   y_r;
  logic [INDEX_WIDTH-1:0] i_r;
  logic                   ovf_r;

  assign dbg_state = state;

  // Handshake: go is sampled only in IDLE; the accepting edge clears done, and
  // done plus the result outputs are held from the FINISH edge until the next
  // accepted go. Overflow is tracked internally and published at FINISH so that
  // every output changes only on the accepting edge or the FINISH edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      v_r      <= '0;
      x_r      <= '0;
      y_r      <= '0;
      i_r      <= '0;
      ovf_r    <= 1'b0;
      index    <= '0;
      fib      <= '0;
      exact    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            v_r      <= v;
            x_r      <= '0;
            y_r      <= {{VALUE_WIDTH{1'b0}}, 1'b1};
            i_r      <= {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
            ovf_r    <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          // A set carry means F(i+1) already exceeds any VALUE_WIDTH-bit value.
          if (!y_r[VALUE_WIDTH] && (y_r[VALUE_WIDTH-1:0] <= v_r)) begin
            state <= STEP;
          end else begin
            state <= FINISH;
          end
        end
        STEP: begin
          if (i_r == INDEX_MAX) begin
            ovf_r <= 1'b1;
            state <= FINISH;
          end else begin
            x_r   <= y_r[VALUE_WIDTH-1:0];
            y_r   <= {1'b0, x_r} + y_r;
            i_r   <= i_r + 1'b1;
            state <= CHECK;
          end
        end
        FINISH: begin
          index    <= i_r;
          fib      <= x_r;
          exact    <= (x_r == v_r);
          overflow <= ovf_r;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_index.sv
// Scoreboard bench for fib_index: a default-width instance (a) and an
// INDEX_WIDTH=4 instance (b) for index saturation.
module tb_fib_index;
  localparam int VW   = 32;
  localparam int A_IW = 6;
  localparam int B_IW = 4;
  localparam int A_W  = A_IW + VW + 2;
  localparam int B_W  = B_IW + VW + 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic            go_a, go_b;
  logic [VW-1:0]   v_a, v_b;
  logic [A_IW-1:0] index_a;
  logic [B_IW-1:0] index_b;
  logic [VW-1:0]   fib_a, fib_b;
  logic            exact_a, exact_b, overflow_a, overflow_b, done_a, done_b;
  logic [1:0]      dbg_state_a, dbg_state_b;

  fib_index #(.VALUE_WIDTH(VW), .INDEX_WIDTH(A_IW)) dut_a (
    .clk(clk), .rst_n(rst_n), .go(go_a), .v(v_a), .index(index_a), .fib(fib_a),
    .exact(exact_a), .overflow(overflow_a), .done(done_a), .dbg_state(dbg_state_a)
  );

  fib_index #(.VALUE_WIDTH(VW), .INDEX_WIDTH(B_IW)) dut_b (
    .clk(clk), .rst_n(rst_n), .go(go_b), .v(v_b), .index(index_b), .fib(fib_b),
    .exact(exact_b), .overflow(overflow_b), .done(done_b), .dbg_state(dbg_state_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // scoreboard: expected {index, fib, exact, overflow} and expected done cycle (-1 = don't care)
  logic [A_W-1:0] exp_a_q[$];
  int             lat_a_q[$];
  logic [B_W-1:0] exp_b_q[$];
  int             lat_b_q[$];
  int res_a_cnt = 0;
  int res_b_cnt = 0;
  int hi_win    = 0;
  int win_lo    = 0;
  int win_hi    = -1;
  logic done_a_q = 1'b0;
  logic done_b_q = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // monitors
  always @(negedge clk) begin
    logic [A_W-1:0] e;
    int l;
    if (done_a && cyc >= win_lo && cyc <= win_hi) hi_win++;
    if (done_a && !done_a_q) begin
      res_a_cnt++;
      if (exp_a_q.size() == 0) begin
        flag("a_unexpected_result");
      end else begin
        e = exp_a_q.pop_front();
        l = lat_a_q.pop_front();
        check("a_result", {index_a, fib_a, exact_a, overflow_a}, e);
        if (l >= 0) check("a_done_cycle", cyc, l);
      end
    end
    done_a_q = done_a;
  end

  always @(negedge clk) begin
    logic [B_W-1:0] e;
    int l;
    if (done_b && !done_b_q) begin
      res_b_cnt++;
      if (exp_b_q.size() == 0) begin
        flag("b_unexpected_result");
      end else begin
        e = exp_b_q.pop_front();
        l = lat_b_q.pop_front();
        check("b_result", {index_b, fib_b, exact_b, overflow_b}, e);
        if (l >= 0) check("b_done_cycle", cyc, l);
      end
    end
    done_b_q = done_b;
  end

  // drivers
  task automatic start_a(input logic [VW-1:0] val, input int ei, input logic [VW-1:0] ef,
                         input logic ee, input logic eo, input int lat, input bit push);
    int acc;
    @(negedge clk);
    go_a = 1'b1;
    v_a  = val;
    @(posedge clk);
    #1;
    acc  = cyc;
    go_a = 1'b0;
    v_a  = $urandom;
    if (push) begin
      exp_a_q.push_back({A_IW'(ei), ef, ee, eo});
      lat_a_q.push_back((lat >= 0) ? acc + lat : -1);
    end
  endtask

  task automatic start_b(input logic [VW-1:0] val, input int ei, input logic [VW-1:0] ef,
                         input logic ee, input logic eo, input int lat);
    int acc;
    @(negedge clk);
    go_b = 1'b1;
    v_b  = val;
    @(posedge clk);
    #1;
    acc  = cyc;
    go_b = 1'b0;
    v_b  = $urandom;
    exp_b_q.push_back({B_IW'(ei), ef, ee, eo});
    lat_b_q.push_back((lat >= 0) ? acc + lat : -1);
  endtask

  task automatic wait_a(input string name);
    for (int i = 0; i < 200 && exp_a_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_a_q.size() != 0) begin
      flag(name);
      exp_a_q.delete();
      lat_a_q.delete();
    end
  endtask

  task automatic wait_b(input string name);
    for (int i = 0; i < 200 && exp_b_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_b_q.size() != 0) begin
      flag(name);
      exp_b_q.delete();
      lat_b_q.delete();
    end
  endtask

  task automatic run_a(input logic [VW-1:0] val, input int ei, input logic [VW-1:0] ef,
                       input logic ee, input logic eo, input int lat);
    start_a(val, ei, ef, ee, eo, lat, 1'b1);
    wait_a("a_timeout");
  endtask

  initial begin
    int r0;
    int c0;
    rst_n = 1'b0;
    go_a  = 1'b1;
    v_a   = 32'd5;
    go_b  = 1'b1;
    v_b   = 32'd5;

    // reset held with go asserted: everything stays 0
    repeat (4) begin
      @(negedge clk);
      check("a_reset_outputs", {index_a, fib_a, exact_a, overflow_a, done_a}, '0);
      check("b_reset_outputs", {index_b, fib_b, exact_b, overflow_b, done_b}, '0);
    end
    go_a  = 1'b0;
    go_b  = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("a_idle_done_after_reset", done_a, 0);
    check("a_idle_state_after_reset", dbg_state_a, 0);

    // small values and carry termination
    run_a(32'd0, 1, 32'd0, 1'b1, 1'b0, 2);
    run_a(32'd1, 3, 32'd1, 1'b1, 1'b0, 6);
    run_a(32'd4, 5, 32'd3, 1'b0, 1'b0, 10);
    run_a(32'hFFFF_FFFF, 48, 32'd2971215073, 1'b0, 1'b0, 96);

    // index saturation on the narrow-index instance
    start_b(32'd1000, 15, 32'd377, 1'b0, 1'b1, -1);
    wait_b("b_timeout_overflow");
    start_b(32'd2, 4, 32'd2, 1'b1, 1'b0, 8);
    wait_b("b_timeout");

    // busy isolation: v and go changes while running are ignored
    r0 = res_a_cnt;
    start_a(32'd100, 12, 32'd89, 1'b0, 1'b0, 24, 1'b1);
    repeat (3) @(negedge clk);
    v_a  = 32'd7;
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    repeat (2) @(negedge clk);
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    wait_a("a_timeout_busy");
    repeat (30) @(negedge clk);
    check("a_busy_single_result", res_a_cnt - r0, 1);
    run_a(32'd7, 6, 32'd5, 1'b0, 1'b0, 12);

    // abort mid-run: outputs clear within the cycle, no result appears
    start_a(32'd1000, 0, 32'd0, 1'b0, 1'b0, -1, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("a_abort_outputs", {index_a, fib_a, exact_a, overflow_a, done_a}, '0);
    check("a_abort_state", dbg_state_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_a(32'd13, 8, 32'd13, 1'b1, 1'b0, 16);

    // go held high for 40 edges: restarts at c0, c0+17, c0+34
    @(negedge clk);
    go_a = 1'b1;
    v_a  = 32'd13;
    @(posedge clk);
    #1;
    c0     = cyc;
    win_lo = c0;
    win_hi = c0 + 50;
    for (int k = 0; k < 3; k++) begin
      exp_a_q.push_back({A_IW'(8), 32'd13, 1'b1, 1'b0});
      lat_a_q.push_back(c0 + 16 + 17 * k);
    end
    repeat (39) @(posedge clk);
    @(negedge clk);
    go_a = 1'b0;
    wait_a("a_timeout_continuous");
    @(negedge clk);
    check("a_continuous_done_high_cycles", hi_win, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
